// File: rtl/dac_config_sequencer_if.sv
// Sequencer bus: start/abort control, register-file read port and the DAC 3-wire serial link.
// master = sequencer side, slave = environment (register file, DAC, slow-control host).
interface dac_config_sequencer_if;
  logic       start;
  logic       abort;
  logic [2:0] rd_addr;
  logic [9:0] rd_data;
  logic       cs_n;
  logic       sclk;
  logic       sdata;
  logic       busy;
  logic       done;

  modport master (
    input  start, abort, rd_data,
    output rd_addr, cs_n, sclk, sdata, busy, done
  );

  modport slave (
    output start, abort, rd_data,
    input  rd_addr, cs_n, sclk, sdata, busy, done
  );
endinterface

// File: rtl/dac_config_sequencer.sv
// Loads DAC registers 0..LAST_ADDR from the register file and shifts each out as a 16-bit frame.
//  state | meaning
//  IDLE  | waiting for start
//  FETCH | rd_addr presented to the register file
//  LOAD  | rd_data framed into the shift register, cs_n asserted
//  SHIFT | 16 sclk periods, MSB first
//  GAP   | cs_n held high between frames
//  DONE  | one-cycle done pulse
module dac_config_sequencer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned LAST_ADDR  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  dac_config_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);
  localparam logic [2:0] LAST       = 3'(LAST_ADDR);

  state_t      state;
  logic [2:0]  addr;
  logic [3:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [14:0] shreg;
  logic [2:0]  rd_addr_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic        sdata_q;
  logic        busy_q;
  logic        done_q;

  logic [3:0]  code;
  logic [15:0] frame;

  assign code  = {1'b0, addr} + 4'd2;
  assign frame = {code, bus.rd_data, 2'b00};

  assign bus.rd_addr = rd_addr_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.sclk    = sclk_q;
  assign bus.sdata   = sdata_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      rd_addr_q <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        // abort has priority over a simultaneous start
        if (bus.start && !bus.abort) begin
          state     <= S_FETCH;
          addr      <= '0;
          rd_addr_q <= '0;
          busy_q    <= 1'b1;
        end
      end else if (bus.abort) begin
        state   <= S_IDLE;
        addr    <= '0;
        bit_cnt <= '0;
        cs_n_q  <= 1'b1;
        sclk_q  <= 1'b0;
        sdata_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          S_FETCH: begin
            state <= S_LOAD;
          end
          S_LOAD: begin
            shreg   <= frame[14:0];
            sdata_q <= frame[15];
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= DIV_RELOAD;
            state   <= S_SHIFT;
          end
          S_SHIFT: begin
            if (div_cnt != 8'd0) begin
              div_cnt <= div_cnt - 8'd1;
            end else begin
              div_cnt <= DIV_RELOAD;
              if (!sclk_q) begin
                sclk_q <= 1'b1;
              end else begin
                // falling sclk: the DAC has sampled the current bit, present the next
                sclk_q <= 1'b0;
                if (bit_cnt == 4'd15) begin
                  cs_n_q  <= 1'b1;
                  sdata_q <= 1'b0;
                  gap_cnt <= GAP_RELOAD;
                  state   <= S_GAP;
                end else begin
                  shreg   <= {shreg[13:0], 1'b0};
                  sdata_q <= shreg[14];
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
            end
          end
          S_GAP: begin
            if (gap_cnt != 8'd0) begin
              gap_cnt <= gap_cnt - 8'd1;
            end else if (addr == LAST) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              addr      <= addr + 3'd1;
              rd_addr_q <= addr + 3'd1;
              state     <= S_FETCH;
            end
          end
          S_DONE: begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_config_sequencer.sv
// Bench for dac_config_sequencer: timeline reference model of the serial frames plus targeted scenarios.
module tb_dac_config_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dac_config_sequencer_if ifa ();
  dac_config_sequencer_if ifb ();

  dac_config_sequencer dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  dac_config_sequencer #(
    .CLK_DIV    (1),
    .GAP_CYCLES (1),
    .LAST_ADDR  (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [9:0] regs [2][8];

  // registered register file: data follows the address by one cycle
  always @(posedge clk) begin
    ifa.rd_data <= regs[0][ifa.rd_addr];
    ifb.rd_data <= regs[1][ifb.rd_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mk(input int a, input logic [9:0] v);
    logic [3:0] c;
    c = 4'(a + 2);
    return {c, v, 2'b00};
  endfunction

  // reference model: a sequence is a timeline starting at the FETCH cycle ts
  bit act [2];
  int ts [2];

  function automatic int p_div(input int d);  return (d != 0) ? 1 : 2; endfunction
  function automatic int p_gap(input int d);  return (d != 0) ? 1 : 4; endfunction
  function automatic int p_last(input int d); return (d != 0) ? 0 : 7; endfunction
  function automatic int p_per(input int d);  return 2 + 32 * p_div(d) + p_gap(d); endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      act[0] <= 1'b0;
      act[1] <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic st, ab;
        st = (d != 0) ? ifb.start : ifa.start;
        ab = (d != 0) ? ifb.abort : ifa.abort;
        if (act[d]) begin
          if (ab || (cyc - ts[d] == (p_last(d) + 1) * p_per(d))) act[d] <= 1'b0;
        end else if (st && !ab) begin
          act[d] <= 1'b1;
          ts[d]  <= cyc + 1;
        end
      end
    end
  end

  task automatic exp_out(input int d, output logic eb, output logic ed, output logic ec,
                         output logic es, output logic esd, output bit sdv);
    int dv, lst, per, r, f, o, k;
    logic [15:0] w;
    dv = p_div(d); lst = p_last(d); per = p_per(d);
    eb = 1'b0; ed = 1'b0; ec = 1'b1; es = 1'b0; esd = 1'b0; sdv = 1'b0;
    if (reset && act[d]) begin
      r = cyc - ts[d];
      if (r == (lst + 1) * per) begin
        eb = 1'b1; ed = 1'b1;
      end else if (r >= 0 && r < (lst + 1) * per) begin
        eb = 1'b1;
        f = r / per;
        o = r % per;
        if (o >= 2 && o < 2 + 32 * dv) begin
          k   = o - 2;
          ec  = 1'b0;
          es  = ((k / dv) % 2) == 1;
          w   = mk(f, regs[d][f[2:0]]);
          esd = w[15 - k / (2 * dv)];
          sdv = 1'b1;
        end
      end
    end
  endtask

  // monitor state
  int busy_cnt [2], done_cnt [2], done_cyc [2], first_busy [2], cs_low_cnt [2], sclk_rise [2];
  int bits [2], next_addr [2];
  logic [15:0] sh [2];
  logic prev_cs [2], prev_sck [2], prev_busy [2];
  int fall_q [$];
  logic [15:0] words_a [$];
  logic [15:0] words_b [$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0; first_busy[d] = 0;
      cs_low_cnt[d] = 0; sclk_rise[d] = 0; bits[d] = 0; next_addr[d] = 0; sh[d] = '0;
      prev_cs[d] = 1'b1; prev_sck[d] = 1'b0; prev_busy[d] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic b, dn, c, s, sd, eb, ed, ec, es, esd;
      bit sdv;
      string p;
      p  = (d != 0) ? "b" : "a";
      b  = (d != 0) ? ifb.busy  : ifa.busy;
      dn = (d != 0) ? ifb.done  : ifa.done;
      c  = (d != 0) ? ifb.cs_n  : ifa.cs_n;
      s  = (d != 0) ? ifb.sclk  : ifa.sclk;
      sd = (d != 0) ? ifb.sdata : ifa.sdata;

      exp_out(d, eb, ed, ec, es, esd, sdv);
      chk({p, ".busy"}, 16'(b), 16'(eb));
      chk({p, ".done"}, 16'(dn), 16'(ed));
      chk({p, ".cs_n"}, 16'(c), 16'(ec));
      chk({p, ".sclk"}, 16'(s), 16'(es));
      if (sdv) chk({p, ".sdata"}, 16'(sd), 16'(esd));
      if (!reset) chk({p, ".sdata_rst"}, 16'(sd), 16'h0);

      if (b) busy_cnt[d]++;
      if (b && !prev_busy[d]) begin first_busy[d] = cyc; next_addr[d] = 0; end
      if (dn) begin done_cnt[d]++; done_cyc[d] = cyc; end
      if (!c) cs_low_cnt[d]++;
      if (!c && prev_cs[d]) begin
        bits[d] = 0;
        if (d == 0) fall_q.push_back(cyc);
      end
      if (s && !prev_sck[d]) begin
        sclk_rise[d]++;
        if (!c) begin sh[d] = {sh[d][14:0], sd}; bits[d]++; end
      end
      if (c && !prev_cs[d]) begin
        if (bits[d] == 16) begin
          chk({p, ".word"}, sh[d], mk(next_addr[d], regs[d][next_addr[d][2:0]]));
          if (d == 0) words_a.push_back(sh[d]); else words_b.push_back(sh[d]);
          next_addr[d]++;
        end
        bits[d] = 0;
      end
      prev_cs[d] = c; prev_sck[d] = s; prev_busy[d] = b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    if (d != 0) ifb.start = 1'b1; else ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0; ifb.start = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int max);
    int n;
    n = 0;
    while (((d != 0) ? ifb.busy : ifa.busy) !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    chk("wait_idle_in_budget", 16'(n < max), 16'h1);
  endtask

  task automatic rand_regs(input int d);
    for (int a = 0; a < 8; a++) regs[d][a] = 10'($urandom);
  endtask

  initial begin
    int b_busy, b_done, b_fall, b_words, b_rise, b_cs, w, do_abort;

    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    for (int a = 0; a < 8; a++) regs[0][a] = 10'(a * 3 + 10'h155);
    rand_regs(1);

    // reset held with random control inputs
    repeat (12) begin
      ifa.start = 1'($urandom); ifa.abort = 1'($urandom);
      ifb.start = 1'($urandom); ifb.abort = 1'($urandom);
      tick();
    end
    chk("rst.a.rd_addr", 16'(ifa.rd_addr), 16'h0);
    chk("rst.b.rd_addr", 16'(ifb.rd_addr), 16'h0);
    ifa.start = 1'b0; ifa.abort = 1'b0; ifb.start = 1'b0; ifb.abort = 1'b0;
    reset = 1'b1;
    repeat (3) tick();

    // full sequence with start re-pulsed during frames 0, 3 and 7
    b_busy = busy_cnt[0]; b_done = done_cnt[0]; b_fall = fall_q.size(); b_words = words_a.size();
    pulse_start(0);
    repeat (10) tick();
    pulse_start(0);
    repeat (220) tick();
    pulse_start(0);
    repeat (280) tick();
    pulse_start(0);
    wait_idle(0, 1000);
    tick();
    chk("full.done_count", 16'(done_cnt[0] - b_done), 16'd1);
    chk("full.busy_cycles", 16'(busy_cnt[0] - b_busy), 16'd561);
    chk("full.frames", 16'(words_a.size() - b_words), 16'd8);
    if (words_a.size() > b_words) chk("full.first_word", words_a[b_words], 16'h2554);
    if (fall_q.size() >= b_fall + 8)
      for (int i = 1; i < 8; i++)
        chk("full.frame_period", 16'(fall_q[b_fall + i] - fall_q[b_fall + i - 1]), 16'd70);

    // abort at bit 5 of frame 2, then restart
    rand_regs(0);
    repeat (2) tick();
    b_done = done_cnt[0];
    pulse_start(0);
    repeat (163) tick();
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("abort.cs_n", 16'(ifa.cs_n), 16'h1);
    chk("abort.sclk", 16'(ifa.sclk), 16'h0);
    chk("abort.busy", 16'(ifa.busy), 16'h0);
    b_rise = sclk_rise[0];
    repeat (40) tick();
    chk("abort.no_sclk", 16'(sclk_rise[0] - b_rise), 16'h0);
    chk("abort.no_done", 16'(done_cnt[0] - b_done), 16'h0);
    b_words = words_a.size();
    pulse_start(0);
    wait_idle(0, 1000);
    tick();
    chk("restart.done", 16'(done_cnt[0] - b_done), 16'd1);
    if (words_a.size() > b_words) chk("restart.frame0", words_a[b_words], mk(0, regs[0][0]));

    // randomized sequences: spurious starts, optional abort at a random point
    for (int it = 0; it < 5; it++) begin
      rand_regs(0);
      tick();
      pulse_start(0);
      w = $urandom_range(0, 620);
      do_abort = $urandom_range(0, 1);
      for (int i = 0; i < w; i++) begin
        ifa.start = ($urandom_range(0, 15) == 0);
        tick();
      end
      ifa.start = 1'b0;
      if (do_abort != 0) begin
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
      end
      wait_idle(0, 1000);
      repeat (3) tick();
    end

    // reset during SHIFT of frame 4
    pulse_start(0);
    repeat (292) tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst.cs_n", 16'(ifa.cs_n), 16'h1);
    chk("midrst.sclk", 16'(ifa.sclk), 16'h0);
    chk("midrst.sdata", 16'(ifa.sdata), 16'h0);
    chk("midrst.busy", 16'(ifa.busy), 16'h0);
    chk("midrst.done", 16'(ifa.done), 16'h0);
    repeat (3) tick();
    reset = 1'b1;
    b_busy = busy_cnt[0];
    repeat (20) tick();
    chk("midrst.stays_idle", 16'(busy_cnt[0] - b_busy), 16'h0);

    // minimal configuration instance
    b_busy = busy_cnt[1]; b_done = done_cnt[1]; b_cs = cs_low_cnt[1]; b_words = words_b.size();
    pulse_start(1);
    wait_idle(1, 200);
    tick();
    chk("edge.done_count", 16'(done_cnt[1] - b_done), 16'd1);
    chk("edge.done_latency", 16'(done_cyc[1] - first_busy[1]), 16'd35);
    chk("edge.shift_cycles", 16'(cs_low_cnt[1] - b_cs), 16'd32);
    chk("edge.busy_cycles", 16'(busy_cnt[1] - b_busy), 16'd36);
    if (words_b.size() > b_words) chk("edge.word", words_b[b_words], {4'b0010, regs[1][0], 2'b00});
    else chk("edge.word_seen", 16'(words_b.size() - b_words), 16'd1);

    // start and abort together while idle
    b_busy = busy_cnt[0];
    ifa.start = 1'b1; ifa.abort = 1'b1;
    tick();
    ifa.start = 1'b0; ifa.abort = 1'b0;
    chk("start_abort.busy", 16'(ifa.busy), 16'h0);
    repeat (5) tick();
    chk("start_abort.no_seq", 16'(busy_cnt[0] - b_busy), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
